// File: rtl/section_min_max_detector.sv
// Splits a signed PCM stream into fixed-length sections and emits each section's
// (min, max) in offset-binary form through a single-entry valid/ready output slot.
module section_min_max_detector #(
    parameter int width          = 16,
    parameter int section_length = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_value,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_min_value,
    output logic [width-1:0] o_max_value
);

    localparam int count_bits = $clog2(section_length);
    localparam logic [count_bits-1:0] LastCount = count_bits'(section_length - 1);

    logic [count_bits-1:0] count_q, count_d;
    logic [width-1:0]      acc_min_q, acc_min_d;
    logic [width-1:0]      acc_max_q, acc_max_d;
    logic [width-1:0]      min_q, min_d;
    logic [width-1:0]      max_q, max_d;
    logic                  valid_q, valid_d;

    logic [width-1:0] u;
    logic             is_last;
    logic             accept;

    // Flipping the sign bit maps two's complement onto an order-preserving unsigned scale.
    assign u       = {~i_value[width-1], i_value[width-2:0]};
    assign is_last = (count_q == LastCount);
    // Only the closing sample needs the slot; earlier samples keep accumulating.
    assign i_ready = !(valid_q && !o_ready && is_last);
    assign accept  = i_valid && i_ready;

    always_comb begin
        count_d   = count_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        min_d     = min_q;
        max_d     = max_q;
        valid_d   = valid_q;

        if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (is_last) begin
                // A same-edge drain and reload leaves valid set with the new result.
                min_d   = (u < acc_min_q) ? u : acc_min_q;
                max_d   = (u > acc_max_q) ? u : acc_max_q;
                valid_d = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
                if (count_q == '0) begin
                    acc_min_d = u;
                    acc_max_d = u;
                end else begin
                    acc_min_d = (u < acc_min_q) ? u : acc_min_q;
                    acc_max_d = (u > acc_max_q) ? u : acc_max_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            acc_min_q <= '0;
            acc_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
            valid_q   <= valid_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_min_value = min_q;
    assign o_max_value = max_q;

endmodule

// File: tb/tb_section_min_max_detector.sv
// Bench for section_min_max_detector: table sections, backpressure, random traffic
// against a reference model with an output scoreboard, reset abort, and a small variant.
module tb_section_min_max_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_ready, o_valid, o_ready;
    logic [15:0] i_value, o_min_value, o_max_value;

    logic        b_i_valid, b_i_ready, b_o_valid, b_o_ready;
    logic [7:0]  b_i_value, b_o_min_value, b_o_max_value;

    always #5 clk = ~clk;

    section_min_max_detector #(.width(16), .section_length(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_value(i_value),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_min_value(o_min_value), .o_max_value(o_max_value)
    );

    section_min_max_detector #(.width(8), .section_length(2)) dut_b (
        .clk(clk), .reset(reset),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_value(b_i_value),
        .o_valid(b_o_valid), .o_ready(b_o_ready),
        .o_min_value(b_o_min_value), .o_max_value(b_o_max_value)
    );

    typedef struct packed {
        logic [15:0] mn;
        logic [15:0] mx;
    } res_t;

    typedef struct {
        logic [15:0] s [4];
        logic [15:0] emin;
        logic [15:0] emax;
    } sec_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;

    int          m_cnt = 0;
    logic [15:0] m_min, m_max;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_accept(logic [15:0] v);
        logic [15:0] u;
        u = {~v[15], v[14:0]};
        if (m_cnt == 0) begin
            m_min = u;
            m_max = u;
        end else begin
            if (u < m_min) m_min = u;
            if (u > m_max) m_max = u;
        end
        if (m_cnt == 3) begin
            q.push_back('{mn: m_min, mx: m_max});
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    logic        hold_v = 1'b0;
    logic [15:0] hold_min, hold_max;
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_min", 32'(o_min_value), 32'(hold_min));
                check("hold_max", 32'(o_max_value), 32'(hold_max));
            end
            if (o_valid && o_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got min 0x%0h max 0x%0h expected none", o_min_value, o_max_value);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    check("res_min", 32'(o_min_value), 32'(e.mn));
                    check("res_max", 32'(o_max_value), 32'(e.mx));
                end
            end
            hold_v   = o_valid && !o_ready;
            hold_min = o_min_value;
            hold_max = o_max_value;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample is taken.
    task automatic send(input logic [15:0] v, input bit use_model);
        int n = 0;
        bit acc = 1'b0;
        i_valid = 1'b1;
        i_value = v;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = i_ready;
            @(posedge clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of 0x%0h", v);
        end else if (use_model) begin
            model_accept(v);
        end
    endtask

    task automatic check_reset_state();
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd1);
        check("rst_o_min", 32'(o_min_value), 32'd0);
        check("rst_o_max", 32'(o_max_value), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_cnt = 0;
        check_reset_state();
    endtask

    task automatic drain();
        int n = 0;
        o_ready = 1'b1;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    sec_t tab [3];
    bit   done_rand;

    initial begin
        tab[0].s = '{16'h0000, 16'h0100, 16'hFF00, 16'h0010};
        tab[0].emin = 16'h7F00; tab[0].emax = 16'h8100;
        tab[1].s = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
        tab[1].emin = 16'h0000; tab[1].emax = 16'hFFFF;
        tab[2].s = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};
        tab[2].emin = 16'h9234; tab[2].emax = 16'h9234;

        reset = 1'b1;
        i_valid = 1'b0; i_value = '0; o_ready = 1'b1;
        b_i_valid = 1'b0; b_i_value = '0; b_o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state();

        // Table sections; latency and one-cycle valid pulse checked on each.
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 4; k++) send(tab[t].s[k], 1'b0);
            q.push_back('{mn: tab[t].emin, mx: tab[t].emax});
            check("tab_valid_rise", 32'(o_valid), 32'd1);
            check("tab_min", 32'(o_min_value), 32'(tab[t].emin));
            check("tab_max", 32'(o_max_value), 32'(tab[t].emax));
            @(posedge clk);
            #1;
            check("tab_valid_fall", 32'(o_valid), 32'd0);
        end

        // Backpressure: 7 accepted, 8th stalls, then same-edge drain and reload.
        o_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(16'(i << 8), 1'b1);
        i_valid = 1'b1;
        i_value = 16'h0800;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", 32'(i_ready), 32'd0);
            check("bp_held_min", 32'(o_min_value), 32'h8100);
            check("bp_held_max", 32'(o_max_value), 32'h8400);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(i_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        model_accept(16'h0800);
        check("bp_reload_valid", 32'(o_valid), 32'd1);
        check("bp_reload_min", 32'(o_min_value), 32'h8500);
        check("bp_reload_max", 32'(o_max_value), 32'h8800);
        o_ready = 1'b1;
        for (int i = 9; i <= 12; i++) send(16'(i << 8), 1'b1);
        drain();

        // Sparse input with random output readiness.
        done_rand = 1'b0;
        fork
            begin
                while (!done_rand) begin
                    @(posedge clk);
                    #1;
                    o_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [15:0] v;
                    case ($urandom_range(0, 7))
                        0: v = 16'h8000;
                        1: v = 16'h7FFF;
                        default: v = 16'($urandom);
                    endcase
                    send(v, 1'b1);
                    repeat (2) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done_rand = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        drain();

        // Reset mid-section and with a pending result.
        send(16'h4000, 1'b1);
        send(16'hC000, 1'b1);
        do_reset();
        o_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(16'(k * 16'h0111), 1'b1);
        check("pend_valid", 32'(o_valid), 32'd1);
        do_reset();
        o_ready = 1'b1;
        send(16'h0005, 1'b1);
        send(16'hFFFB, 1'b1);
        send(16'h0003, 1'b1);
        send(16'h0001, 1'b1);
        check("post_rst_min", 32'(o_min_value), 32'h7FFB);
        check("post_rst_max", 32'(o_max_value), 32'h8005);
        drain();

        // Narrow, two-sample variant.
        b_i_valid = 1'b1;
        b_i_value = 8'h80;
        check("b_ready", 32'(b_i_ready), 32'd1);
        @(posedge clk);
        #1;
        b_i_value = 8'h7F;
        check("b_mid_valid", 32'(b_o_valid), 32'd0);
        @(posedge clk);
        #1;
        b_i_value = 8'h01;
        check("b_valid", 32'(b_o_valid), 32'd1);
        check("b_min", 32'(b_o_min_value), 32'h00);
        check("b_max", 32'(b_o_max_value), 32'hFF);
        @(posedge clk);
        #1;
        b_i_value = 8'h02;
        check("b_wrap_valid", 32'(b_o_valid), 32'd0);
        @(posedge clk);
        #1;
        b_i_valid = 1'b0;
        check("b_wrap_min", 32'(b_o_min_value), 32'h81);
        check("b_wrap_max", 32'(b_o_max_value), 32'h82);

        @(posedge clk);
        #1;
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
